// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states, debug error reasons.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dmem_pkg;

   // RISC-V load/store funct3 encodings (stores use only B/H/W)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Error reasons, kept for waveform/debug decoding
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_RANGE    = 2'd2;
   localparam logic [1:0] ERR_FUNCT3   = 2'd3;

   // Stores accept B/H/W; loads additionally accept BU/HU
   function automatic logic f3_legal(input logic write, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!write) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        busy;

   modport master (
      output req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error, busy
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: store byte-mask/merge, load extraction with sign/zero extension, misalign flag.
// Latency: purely combinational.
// Backpressure: none; caller decides when the results are used.
module lsu_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_rword,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_wmask,
   output logic [31:0] o_wword,
   output logic [31:0] o_rdata,
   output logic        o_misalign
);
   logic [4:0]  w_shamt;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_wshift;

   // Pick the addressed lanes and decode size/extension from funct3
   always_comb begin
      w_shamt    = {i_addr_lo, 3'b000};
      w_byte     = i_rword[w_shamt +: 8];
      w_half     = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
      w_wshift   = i_wdata << w_shamt;
      o_wmask    = 4'b0000;
      o_rdata    = 32'h0;
      o_misalign = 1'b0;
      case (i_funct3)
         F3_B: begin
            o_wmask = 4'b0001 << i_addr_lo;
            o_rdata = {{24{w_byte[7]}}, w_byte};
         end
         F3_BU: begin
            o_wmask = 4'b0001 << i_addr_lo;
            o_rdata = {24'h0, w_byte};
         end
         F3_H: begin
            o_wmask    = 4'b0011 << i_addr_lo;
            o_rdata    = {{16{w_half[15]}}, w_half};
            o_misalign = i_addr_lo[0];
         end
         F3_HU: begin
            o_wmask    = 4'b0011 << i_addr_lo;
            o_rdata    = {16'h0, w_half};
            o_misalign = i_addr_lo[0];
         end
         F3_W: begin
            o_wmask    = 4'b1111;
            o_rdata    = i_rword;
            o_misalign = |i_addr_lo;
         end
         default: begin
         end
      endcase
   end

   // Merge shifted store data into the old word, lane by lane
   always_comb begin
      o_wword = i_rword;
      for (int i = 0; i < 4; i++) begin
         if (o_wmask[i]) begin
            o_wword[8*i +: 8] = w_wshift[8*i +: 8];
         end
      end
   end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for MEM-stage loads/stores with WAIT_STATES (0..15) programmable wait cycles.
// Latency: response visible WAIT_STATES+1 cycles after the accept cycle; one request outstanding.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic            clock,
   input  logic            reset,
   dmem_responder_if.slave bus
);
   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   state_e      r_state;
   logic [3:0]  r_cnt;
   logic        r_write;
   logic [31:0] r_addr;
   logic [2:0]  r_funct3;
   logic [31:0] r_wdata;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_error;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic             w_write;
   logic [31:0]      w_addr;
   logic [2:0]       w_funct3;
   logic [31:0]      w_wdata;
   logic [31:0]      w_offset;
   logic [IDX_W-1:0] w_idx;
   logic             w_in_range;
   logic [31:0]      w_rword;
   logic [3:0]       w_wmask;
   logic [31:0]      w_wword;
   logic [31:0]      w_ldata;
   logic             w_misalign;
   logic             w_err;
   logic             w_access;
   logic [31:0]      w_rsp_rdata;

   // With zero wait states the access happens on the accept edge, so the datapath
   // reads the live request in IDLE and the captured copy otherwise.
   always_comb begin
      if (r_state == IDLE) begin
         w_write  = bus.req_write;
         w_addr   = bus.req_addr;
         w_funct3 = bus.req_funct3;
         w_wdata  = bus.req_wdata;
      end else begin
         w_write  = r_write;
         w_addr   = r_addr;
         w_funct3 = r_funct3;
         w_wdata  = r_wdata;
      end
   end

   // Address decode; the 33-bit compare makes a wrap below BASE_ADDR out-of-range
   always_comb begin
      w_offset    = w_addr - BASE_ADDR;
      w_idx       = w_offset[IDX_W+1:2];
      w_in_range  = ({1'b0, w_offset} < LIMIT);
      w_rword     = w_in_range ? r_mem[w_idx] : 32'h0;
      w_err       = !w_in_range || w_misalign || !f3_legal(w_write, w_funct3);
      w_access    = ((r_state == IDLE) && bus.req_valid && (WS == 4'd0)) ||
                    ((r_state == WAIT) && (r_cnt == 4'd1));
      w_rsp_rdata = (w_write || w_err) ? 32'h0 : w_ldata;
   end

   lsu_lane_align u_align (
      .i_funct3   (w_funct3),
      .i_addr_lo  (w_addr[1:0]),
      .i_rword    (w_rword),
      .i_wdata    (w_wdata),
      .o_wmask    (w_wmask),
      .o_wword    (w_wword),
      .o_rdata    (w_ldata),
      .o_misalign (w_misalign)
   );

   // Storage write on the edge that enters RESP; contents survive reset
   always_ff @(posedge clock) begin
      if (w_access && w_write && !w_err && (|w_wmask)) begin
         r_mem[w_idx] <= w_wword;
      end
   end

   // Request capture, wait-state countdown and response registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_write     <= 1'b0;
         r_addr      <= 32'h0;
         r_funct3    <= 3'b000;
         r_wdata     <= 32'h0;
         r_rsp_rdata <= 32'h0;
         r_rsp_error <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_write  <= bus.req_write;
                  r_addr   <= bus.req_addr;
                  r_funct3 <= bus.req_funct3;
                  r_wdata  <= bus.req_wdata;
                  if (WS == 4'd0) begin
                     r_state <= RESP;
                  end else begin
                     r_cnt   <= WS;
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_access) begin
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_error <= w_err;
         end
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_error = r_rsp_error;
   assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, randomized traffic vs. a byte-level model.
// Latency: counted in clock edges from the accept edge (inclusive) to rsp_valid high.
// Backpressure: rsp_ready is held low in RESP and asserted early during WAIT.
module tb_dmem_responder;
   import dmem_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   dmem_responder_if bus0 ();
   dmem_responder_if bus1 ();

   logic        t_vld  [2];
   logic        t_wr   [2];
   logic [31:0] t_addr [2];
   logic [2:0]  t_f3   [2];
   logic [31:0] t_wd   [2];
   logic        t_rrdy [2];

   assign bus0.req_valid  = t_vld[0];
   assign bus0.req_write  = t_wr[0];
   assign bus0.req_addr   = t_addr[0];
   assign bus0.req_funct3 = t_f3[0];
   assign bus0.req_wdata  = t_wd[0];
   assign bus0.rsp_ready  = t_rrdy[0];
   assign bus1.req_valid  = t_vld[1];
   assign bus1.req_write  = t_wr[1];
   assign bus1.req_addr   = t_addr[1];
   assign bus1.req_funct3 = t_f3[1];
   assign bus1.req_wdata  = t_wd[1];
   assign bus1.rsp_ready  = t_rrdy[1];

   // d0: zero wait states, small memory at a non-zero base
   dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) dut0 (
      .clock (clock), .reset (reset), .bus (bus0)
   );
   // d1: default configuration, one wait state
   dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) dut1 (
      .clock (clock), .reset (reset), .bus (bus1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic get_rdy(input int d);
      return (d == 1) ? bus1.req_ready : bus0.req_ready;
   endfunction
   function automatic logic get_rv(input int d);
      return (d == 1) ? bus1.rsp_valid : bus0.rsp_valid;
   endfunction
   function automatic logic [31:0] get_rd(input int d);
      return (d == 1) ? bus1.rsp_rdata : bus0.rsp_rdata;
   endfunction
   function automatic logic get_re(input int d);
      return (d == 1) ? bus1.rsp_error : bus0.rsp_error;
   endfunction
   function automatic logic get_busy(input int d);
      return (d == 1) ? bus1.busy : bus0.busy;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One complete request/response; lat = edges from accept edge to rsp_valid
   task automatic xact(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd, input bit early,
                       output logic [31:0] rd, output logic err, output int lat);
      int n;
      @(negedge clock);
      t_wr[d] = wr; t_addr[d] = addr; t_f3[d] = f3; t_wd[d] = wd; t_vld[d] = 1'b1;
      n = 0;
      while (!get_rdy(d) && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20) chk("accept_timeout", get_rdy(d), 1);
      @(posedge clock);
      lat = 1;
      @(negedge clock);
      t_vld[d] = 1'b0;
      if (early) t_rrdy[d] = 1'b1;
      while (!get_rv(d) && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      rd  = get_rd(d);
      err = get_re(d);
      t_rrdy[d] = 1'b1;
      @(negedge clock);
      t_rrdy[d] = 1'b0;
   endtask

   // Reference model: byte-granular little-endian memory, base 0, 1024 words
   logic [31:0] mdl [int];

   task automatic model(input bit wr, input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                        output logic [31:0] erd, output logic eerr);
      int size;
      bit sgn;
      int b;
      logic [31:0] w, v;
      size = 0; sgn = 0;
      case (f3)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: size = 4;
         3'd4: size = 1;
         3'd5: size = 2;
         default: size = 0;
      endcase
      if (size == 0 || (wr && f3[2])) eerr = 1'b1;
      else eerr = ((addr % size) != 0) || (addr >= 32'd4096);
      erd = 32'h0;
      if (!eerr) begin
         w = mdl[int'(addr >> 2)];
         b = int'(addr % 4);
         if (wr) begin
            for (int i = 0; i < size; i++) w[8*(b+i) +: 8] = wd[8*i +: 8];
            mdl[int'(addr >> 2)] = w;
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = w[8*(b+i) +: 8];
            if (sgn && size < 4 && v[8*size-1]) begin
               for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            erd = v;
         end
      end
   endtask

   typedef struct {
      int          d;
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;
   vec_t vecs[$];

   function automatic void add(int d, bit wr, logic [31:0] a, logic [2:0] f, logic [31:0] wd,
                               logic [31:0] erd, bit e);
      vec_t v;
      v.d = d; v.wr = wr; v.addr = a; v.f3 = f; v.wd = wd; v.exp_rd = erd; v.exp_err = e;
      vecs.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd, erd, a, wd;
      logic        er, eer;
      logic [2:0]  f;
      bit          wr;
      int          lat, acc, rvn, n;

      for (int d = 0; d < 2; d++) begin
         t_vld[d] = 0; t_wr[d] = 0; t_addr[d] = 0; t_f3[d] = 0; t_wd[d] = 0; t_rrdy[d] = 0;
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst%0d_rsp_valid", d), get_rv(d), 0);
         chk($sformatf("rst%0d_rsp_rdata", d), get_rd(d), 0);
         chk($sformatf("rst%0d_rsp_error", d), get_re(d), 0);
         chk($sformatf("rst%0d_busy", d), get_busy(d), 0);
      end
      reset = 1'b1;
      @(negedge clock);

      // ---------------- directed vector table ----------------
      add(1, 1, 32'h10, F3_W,  32'hDEADBEEF, 32'h0,        0);
      add(1, 0, 32'h10, F3_W,  32'h0,        32'hDEADBEEF, 0);
      add(1, 0, 32'h13, F3_B,  32'h0,        32'hFFFFFFDE, 0);
      add(1, 0, 32'h13, F3_BU, 32'h0,        32'h000000DE, 0);
      add(1, 0, 32'h12, F3_H,  32'h0,        32'hFFFFDEAD, 0);
      add(1, 0, 32'h10, F3_HU, 32'h0,        32'h0000BEEF, 0);
      add(1, 1, 32'h11, F3_B,  32'h55,       32'h0,        0);
      add(1, 0, 32'h10, F3_W,  32'h0,        32'hDEAD55EF, 0);
      add(1, 0, 32'h12, F3_W,  32'h0,        32'h0,        1);
      add(1, 1, 32'h11, F3_H,  32'h1234,     32'h0,        1);
      add(1, 0, 32'h10, F3_W,  32'h0,        32'hDEAD55EF, 0);
      add(1, 0, 32'h1000, F3_W, 32'h0,       32'h0,        1);
      add(1, 0, 32'h10, 3'b011, 32'h0,       32'h0,        1);
      add(1, 1, 32'h10, F3_BU, 32'h77,       32'h0,        1);
      add(1, 0, 32'hFFFFFFFC, F3_W, 32'h0,   32'h0,        1);
      add(1, 1, 32'h20, F3_W,  32'h0,        32'h0,        0);
      add(0, 1, 32'h10FC, F3_W, 32'hA5A50F0F, 32'h0,       0);
      add(0, 0, 32'h10FE, F3_H, 32'h0,       32'hFFFFA5A5, 0);
      add(0, 0, 32'h10FD, F3_BU, 32'h0,      32'h0000000F, 0);
      add(0, 0, 32'h1100, F3_W, 32'h0,       32'h0,        1);
      add(0, 0, 32'h0FFC, F3_W, 32'h0,       32'h0,        1);
      add(0, 1, 32'h10FE, F3_H, 32'h8001,    32'h0,        0);
      add(0, 0, 32'h10FC, F3_W, 32'h0,       32'h80010F0F, 0);
      add(0, 0, 32'h10FF, F3_B, 32'h0,       32'hFFFFFF80, 0);

      foreach (vecs[i]) begin
         xact(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].f3, vecs[i].wd, 1'b0, rd, er, lat);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d_error", i), er, vecs[i].exp_err);
         chk($sformatf("vec%0d_latency", i), lat, (vecs[i].d == 1) ? 2 : 1);
      end

      // ---------------- response backpressure on d1 ----------------
      @(negedge clock);
      t_wr[1] = 0; t_addr[1] = 32'h10; t_f3[1] = F3_W; t_vld[1] = 1;
      @(posedge clock);
      @(negedge clock);
      t_vld[1] = 0;
      n = 0;
      while (!get_rv(1) && n < 20) begin
         @(negedge clock);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d_rsp_valid", i), get_rv(1), 1);
         chk($sformatf("bp%0d_rsp_rdata", i), get_rd(1), 32'hDEAD55EF);
         chk($sformatf("bp%0d_req_ready", i), get_rdy(1), 0);
         if (i == 1) begin
            t_wr[1] = 1; t_addr[1] = 32'h10; t_f3[1] = F3_W; t_wd[1] = 32'h0; t_vld[1] = 1;
         end
         if (i == 2) t_vld[1] = 0;
         @(negedge clock);
      end
      t_rrdy[1] = 1;
      @(negedge clock);
      t_rrdy[1] = 0;
      chk("bp_release_rsp_valid", get_rv(1), 0);
      xact(1, 0, 32'h10, F3_W, 32'h0, 1'b0, rd, er, lat);
      chk("bp_pulse_ignored", rd, 32'hDEAD55EF);

      // ---------------- reset while in WAIT ----------------
      @(negedge clock);
      t_wr[1] = 1; t_addr[1] = 32'h20; t_f3[1] = F3_W; t_wd[1] = 32'h12345678; t_vld[1] = 1;
      @(posedge clock);
      @(negedge clock);
      t_vld[1] = 0;
      chk("rstwait_busy_before", get_busy(1), 1);
      #1 reset = 1'b0;
      #1;
      chk("rstwait_busy", get_busy(1), 0);
      chk("rstwait_rsp_valid", get_rv(1), 0);
      chk("rstwait_rsp_rdata", get_rd(1), 0);
      chk("rstwait_rsp_error", get_re(1), 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk($sformatf("rstwait_no_rsp%0d", i), get_rv(1), 0);
      end
      xact(1, 0, 32'h20, F3_W, 32'h0, 1'b0, rd, er, lat);
      chk("rstwait_no_write", rd, 32'h0);

      // ---------------- back-to-back on d0 (zero wait states) ----------------
      @(negedge clock);
      t_wr[0] = 0; t_addr[0] = 32'h10FC; t_f3[0] = F3_W; t_vld[0] = 1; t_rrdy[0] = 1;
      acc = 0; rvn = 0;
      for (int i = 0; i < 10; i++) begin
         if (get_rdy(0)) acc++;
         if (get_rv(0)) begin
            rvn++;
            chk($sformatf("b2b%0d_rdata", i), get_rd(0), 32'h80010F0F);
         end
         chk($sformatf("b2b%0d_valid_phase", i), get_rv(0), i % 2);
         @(negedge clock);
      end
      t_vld[0] = 0; t_rrdy[0] = 0;
      chk("b2b_accepts", acc, 5);
      chk("b2b_responses", rvn, 5);

      // ---------------- randomized traffic vs. model on d1 ----------------
      for (int w = 0; w < 16; w++) begin
         a  = 32'h100 + 32'(4 * w);
         wd = $urandom;
         mdl[int'(a >> 2)] = 32'h0;
         model(1'b1, a, F3_W, wd, erd, eer);
         xact(1, 1'b1, a, F3_W, wd, 1'b0, rd, er, lat);
         chk($sformatf("pre%0d_error", w), er, eer);
      end
      for (int i = 0; i < 150; i++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 255));
         else a = 32'h100 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) f = 3'($urandom_range(0, 7));
         else begin
            case ($urandom_range(0, 4))
               0: f = F3_B;
               1: f = F3_H;
               2: f = F3_W;
               3: f = F3_BU;
               default: f = F3_HU;
            endcase
         end
         wd = $urandom;
         model(wr, a, f, wd, erd, eer);
         xact(1, wr, a, f, wd, 1'($urandom_range(0, 1)), rd, er, lat);
         chk($sformatf("rnd%0d_rdata", i), rd, erd);
         chk($sformatf("rnd%0d_error", i), er, eer);
         chk($sformatf("rnd%0d_latency", i), lat, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target that serves the core's MEM-stage load/store requests over a valid/ready request channel and a valid/ready response channel.
- Holds word-organised storage and performs RISC-V byte/half/word accesses using funct3 encoding, including little-endian lane steering and sign/zero extension.
- Inserts a configurable number of wait states, so core stall and handshake logic is exercised against a non-zero-latency memory.
- Accepts one outstanding request at a time.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words of storage.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- WAIT_STATES, 1: cycles spent in WAIT before the access completes; legal range 0..15.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; asserted at 0.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  access size and extension (RISC-V load/store funct3).
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load result after extension; 0 for stores and for errors.
- rsp_error  out  1  misaligned, out-of-range or illegal funct3.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0, wait counter=0, captured request cleared. Storage contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, capture write, addr, funct3 and wdata, and compute error.
  - If WAIT_STATES=0, perform the access and go to RESP next cycle.
  - Otherwise load counter=WAIT_STATES and go to WAIT.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter=1, perform the access and go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error remain stable until rsp_ready=1.
  - On rsp_ready=1, go to IDLE. req_ready stays 0 in RESP, so a new request cannot be accepted in the same cycle.
- Latency: request accept edge to rsp_valid high is WAIT_STATES+1 cycles. Best-case throughput is one request per WAIT_STATES+2 cycles.
- Access point: the storage write and the rdata capture occur on the edge that enters RESP. Loads see all earlier completed stores; there is no forwarding inside a request.
- Address decode: offset = req_addr - BASE_ADDR; word index = offset[31:2]; out-of-range when offset >= DEPTH_WORDS*4, with unsigned wrap treated as out-of-range.
- Alignment rules:
  - halfword requires addr[0]=0.
  - word requires addr[1:0]=0.
  - byte accesses are always aligned.
- Legal funct3:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is an error.
- Loads: select the byte or half by addr[1:0] (little-endian). LB/LH sign-extend; LBU/LHU zero-extend.
- Stores: write only the addressed byte lanes from req_wdata[7:0], [15:0] or [31:0]; other lanes are unchanged.
- On error: no storage write, rsp_rdata=0, rsp_error=1, and the response handshake proceeds normally.
- Input rules: req_valid while not in IDLE is ignored; the requester must hold its request until req_ready. A rsp_ready that arrives early (before RESP) has no effect.
- Reset mid-operation: an access still in WAIT is abandoned with no write, and no response is produced after reset is released.

Decomposition:
- Shared package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum {IDLE, WAIT, RESP}.
  - an error-reason localparam set for debug.
- One natural sub-module, lsu_lane_align (combinational): it takes funct3, addr[1:0], the stored word and wdata, and produces the write byte-mask, the merged write word, the extended load data and the misalign flag.

Test Plan:
- WAIT_STATES=1, SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> rsp_rdata=0xDEADBEEF, rsp_error=0, rsp_valid exactly 2 cycles after each accept edge.
- After word 0x10=0xDEADBEEF:
  - LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
  - SB 0x11 data 0x55 then LW 0x10 -> 0xDEAD55EF.
- Error cases:
  - LW 0x12 -> rsp_error=1, rdata=0.
  - SH 0x11 -> rsp_error=1; LW 0x10 then shows the word unchanged.
  - LW at BASE_ADDR+DEPTH_WORDS*4 -> rsp_error=1.
  - Load funct3=011 -> rsp_error=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; a req_valid pulse during this time is not accepted.
- WAIT_STATES=0: back-to-back requests -> accepts every 2 cycles, rsp_valid 1 cycle after accept.
- Reset: assert reset=0 asynchronously while in WAIT of SW 0x20 data 0x12345678 -> outputs zero immediately; after release, LW 0x20 does not return 0x12345678 (pre-loaded 0 reads 0).
